// File: rtl/word_block_assembler.sv
// -----------------------------------------------------------------------------
// word_block_assembler
//
// Gathers NUM_WORDS words of WORD_W bits into one block and offers the block
// to a consumer on a valid/ready interface. A block can be closed early with
// in_last, and a partial or held block can be dropped with clear. MSW_FIRST
// selects whether the first word of a block lands in the most- or the
// least-significant slot. The default build produces 128-bit AES message/key
// blocks from a 32-bit word-serial host.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   RESET      synchronous reset, active-low
//   clear      synchronous abort of the partial or held block
//   in_valid   in_word is valid
//   in_ready   a word is accepted this cycle when in_valid is also high
//   in_word    input word
//   in_last    with an accepted word: close the block after this word
//   out_valid  out_block holds a complete block
//   out_ready  consumer takes the block this cycle
//   out_block  assembled block, unfilled slots read zero
//   out_count  number of valid words in out_block (0 while filling)
// -----------------------------------------------------------------------------
module word_block_assembler #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter bit MSW_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_word,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_block,
  output logic [CNT_W-1:0]            out_count
);

  localparam int BLOCK_W = WORD_W * NUM_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     idx;
  logic [BLOCK_W-1:0]   block;
  logic                 accept;

  // Returns 'base' with word 'w' written into the slot that belongs to word
  // index 'i' under the selected word order.
  function automatic logic [BLOCK_W-1:0] place(
    input logic [BLOCK_W-1:0] base,
    input logic [CNT_W-1:0]   i,
    input logic [WORD_W-1:0]  w
  );
    logic [BLOCK_W-1:0] r;
    int                 slot;
    r    = base;
    slot = MSW_FIRST ? (NUM_WORDS - 1 - int'(i)) : int'(i);
    r[slot*WORD_W +: WORD_W] = w;
    return r;
  endfunction

  // While a block is held, a new word may only enter in the same cycle the
  // held block leaves, so out_ready feeds in_ready combinationally and the
  // stream keeps one word per cycle across block boundaries.
  assign in_ready  = RESET && ((state == FILL) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_block = block;

  // Single state machine: reset beats clear, clear beats any handshake, and a
  // word presented during clear is dropped.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state     <= FILL;
      idx       <= '0;
      block     <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= FILL;
      idx       <= '0;
      block     <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            block <= place(block, idx, in_word);
            if ((idx == LAST_IDX) || in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_count <= idx + CNT_W'(1);
              idx       <= '0;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            if (accept) begin
              // The held block leaves and the new word starts a fresh block.
              // With NUM_WORDS >= 2 only in_last can close it immediately.
              block <= place('0, '0, in_word);
              if (in_last) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_count <= CNT_W'(1);
                idx       <= '0;
              end else begin
                state     <= FILL;
                out_valid <= 1'b0;
                out_count <= '0;
                idx       <= CNT_W'(1);
              end
            end else begin
              state     <= FILL;
              out_valid <= 1'b0;
              block     <= '0;
              out_count <= '0;
              idx       <= '0;
            end
          end
        end

        default: begin
          state     <= FILL;
          idx       <= '0;
          block     <= '0;
          out_count <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_block_assembler.sv
// -----------------------------------------------------------------------------
// tb_word_block_assembler
//
// Drives two 32x4 assemblers (MSW-first and LSW-first) in lockstep from the
// same inputs and compares them each cycle against a queue-based model of the
// block-gathering rules. A third 8x3 instance gets a few directed words.
// -----------------------------------------------------------------------------
module tb_word_block_assembler;

  logic         clk = 1'b0;
  logic         RESET;
  logic         clear;
  logic         in_valid;
  logic [31:0]  in_word;
  logic         in_last;
  logic         out_ready;

  logic         a_in_ready, b_in_ready;
  logic         a_out_valid, b_out_valid;
  logic [127:0] a_out_block, b_out_block;
  logic [2:0]   a_out_count, b_out_count;

  logic         c_in_valid;
  logic [7:0]   c_in_word;
  logic         c_in_last;
  logic         c_out_ready;
  logic         c_in_ready;
  logic         c_out_valid;
  logic [23:0]  c_out_block;
  logic [1:0]   c_out_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: words of the block being gathered, and the held block if any.
  logic [31:0] m_words[$];
  logic [31:0] m_held[$];
  bit          m_valid;

  always #5 clk = ~clk;

  word_block_assembler #(.WORD_W(32), .NUM_WORDS(4), .MSW_FIRST(1'b1)) dut_a (
    .clk(clk), .RESET(RESET), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_word(in_word), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_block(a_out_block), .out_count(a_out_count)
  );

  word_block_assembler #(.WORD_W(32), .NUM_WORDS(4), .MSW_FIRST(1'b0)) dut_b (
    .clk(clk), .RESET(RESET), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_word(in_word), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_block(b_out_block), .out_count(b_out_count)
  );

  word_block_assembler #(.WORD_W(8), .NUM_WORDS(3), .MSW_FIRST(1'b1)) dut_c (
    .clk(clk), .RESET(RESET), .clear(clear),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_word(c_in_word), .in_last(c_in_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_block(c_out_block), .out_count(c_out_count)
  );

  // First word in the top 32 bits.
  function automatic logic [127:0] build_msw(input logic [31:0] q[$]);
    logic [127:0] r = '0;
    for (int i = 0; i < q.size(); i++) r = r | (128'(q[i]) << (32 * (3 - i)));
    return r;
  endfunction

  // First word in the bottom 32 bits.
  function automatic logic [127:0] build_lsw(input logic [31:0] q[$]);
    logic [127:0] r = '0;
    for (int i = 0; i < q.size(); i++) r = r | (128'(q[i]) << (32 * i));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive the shared inputs, check in_ready before the edge,
  // advance the model across the edge, then check the registered outputs.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic l,
                               input logic r, input logic c, input logic rst);
    logic         exp_ready;
    logic [127:0] exp_count;
    in_valid  = v;
    in_word   = w;
    in_last   = l;
    out_ready = r;
    clear     = c;
    RESET     = rst;
    #1;
    exp_ready = rst && (!m_valid || r);
    checkOutput("a_in_ready", 128'(a_in_ready), 128'(exp_ready));
    checkOutput("b_in_ready", 128'(b_in_ready), 128'(exp_ready));

    @(posedge clk);
    if (!rst || c) begin
      m_words.delete();
      m_held.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && r) begin
        m_valid = 1'b0;
        m_held.delete();
      end
      if (v && exp_ready) begin
        m_words.push_back(w);
        if (m_words.size() == 4 || l) begin
          m_held  = m_words;
          m_words.delete();
          m_valid = 1'b1;
        end
      end
    end
    #1;

    exp_count = m_valid ? 128'(m_held.size()) : 128'(0);
    checkOutput("a_out_valid", 128'(a_out_valid), 128'(m_valid));
    checkOutput("b_out_valid", 128'(b_out_valid), 128'(m_valid));
    checkOutput("a_out_count", 128'(a_out_count), exp_count);
    checkOutput("b_out_count", 128'(b_out_count), exp_count);
    if (m_valid) begin
      checkOutput("a_out_block", a_out_block, build_msw(m_held));
      checkOutput("b_out_block", b_out_block, build_lsw(m_held));
    end
  endtask

  initial begin
    m_valid     = 1'b0;
    c_in_valid  = 1'b0;
    c_in_word   = 8'h00;
    c_in_last   = 1'b0;
    c_out_ready = 1'b0;

    // Reset for two cycles, then check the cleared outputs.
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_a_block", a_out_block, 128'h0);
    checkOutput("reset_c_valid", 128'(c_out_valid), 128'h0);
    checkOutput("reset_c_count", 128'(c_out_count), 128'h0);

    // Full block, both word orders.
    applyStimulus(1'b1, 32'h0011_2233, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h4455_6677, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8899_AABB, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hCCDD_EEFF, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("full_msw_block", a_out_block, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    checkOutput("full_lsw_block", b_out_block, 128'hCCDDEEFF_8899AABB_44556677_00112233);
    checkOutput("full_count", 128'(a_out_count), 128'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Early close after two words.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0102_0304, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("early_block", a_out_block, 128'hDEADBEEF_01020304_00000000_00000000);
    checkOutput("early_count", 128'(a_out_count), 128'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Back-pressure for five cycles, then handoff with a simultaneous word.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall_block", a_out_block, 128'h10000000_10000001_10000002_10000003);
    applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h2000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("overlap_block", a_out_block, 128'hA5A5A5A5_20000000_20000001_20000002);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Clear after two words, with a word dropped in the clear cycle.
    applyStimulus(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_block", a_out_block, 128'h30000000_30000001_30000002_30000003);
    checkOutput("clear_count", 128'(a_out_count), 128'd4);

    // Clear while holding, then reset while holding.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h4000_0000 + i, (i == 2), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midhold_reset_block", a_out_block, 128'h0);
    checkOutput("midhold_reset_count", 128'(a_out_count), 128'h0);

    // Randomised traffic with occasional clear and reset.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(3) != 0), $urandom, ($urandom_range(4) == 0),
                    ($urandom_range(1) == 1), ($urandom_range(24) == 0),
                    ($urandom_range(49) != 0));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Narrow 8x3 instance: full block, then a one-word early close.
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_word   = 8'h11;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    c_in_word   = 8'h22;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    c_in_word   = 8'h33;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("narrow_valid", 128'(c_out_valid), 128'd1);
    checkOutput("narrow_block", 128'(c_out_block), 128'h112233);
    checkOutput("narrow_count", 128'(c_out_count), 128'd3);
    checkOutput("narrow_in_ready_held", 128'(c_in_ready), 128'd0);
    c_out_ready = 1'b1;
    c_in_word   = 8'h44;
    c_in_last   = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("narrow_last_valid", 128'(c_out_valid), 128'd1);
    checkOutput("narrow_last_block", 128'(c_out_block), 128'h440000);
    checkOutput("narrow_last_count", 128'(c_out_count), 128'd1);
    c_in_valid  = 1'b0;
    c_in_last   = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("narrow_drain_valid", 128'(c_out_valid), 128'd0);
    checkOutput("narrow_drain_count", 128'(c_out_count), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
